reg_file: RTL and testbench

- Architectural register file with per-register rename tags for the Tomasulo core.
- Sits between the ROB and the Decoder:
  - Downstream of the ROB: consumes in-order commits.
  - Upstream of the Decoder/RS: answers operand queries with a value, or with the ROB id of the pending producer.
- Flushes all rename tags when the ROB raises rob_clear.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/rf_read_port.sv | 47 ++++
 rtl/reg_file.sv | 101 ++++++++++
 tb/tb_reg_file.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared core configuration: ROB id width, register id width, word type.
// Imported by the register file and its read ports.
package reg_file_pkg;

   localparam int ROB_SIZE_BIT = 4;
   localparam int REG_ID_BIT   = 5;
   localparam int REG_NUM      = 32;
   localparam int XLEN         = 32;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ID_BIT-1:0] reg_id_t;

   function automatic logic is_x0(input reg_id_t r);
      return r == '0;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One operand query port: x0 forcing plus optional commit bypass (RF_COMMIT_BYPASS_EN).
// Purely combinational, 0-cycle latency; no backpressure.
import reg_file_pkg::*;

module rf_read_port #(
   parameter int ROB_SIZE_BIT = reg_file_pkg::ROB_SIZE_BIT
) (
   input  logic [REG_ID_BIT-1:0]   qry_reg,
   input  logic [XLEN-1:0]         reg_value,
   input  logic                    reg_busy,
   input  logic [ROB_SIZE_BIT-1:0] reg_tag,
   input  logic                    commit_en,
   input  logic [REG_ID_BIT-1:0]   commit_reg,
   input  logic [XLEN-1:0]         commit_value,
   input  logic [ROB_SIZE_BIT-1:0] commit_rob_id,
   output logic [XLEN-1:0]         qry_value,
   output logic                    qry_busy,
   output logic [ROB_SIZE_BIT-1:0] qry_rob_id
);

`ifdef RF_COMMIT_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic bypass_hit;

   // Only the commit that retires the current producer may stand in for it.
   assign bypass_hit = BYPASS_EN && commit_en && (commit_reg == qry_reg)
                       && reg_busy && (reg_tag == commit_rob_id);

   always_comb begin
      qry_value  = reg_value;
      qry_busy   = reg_busy;
      qry_rob_id = reg_tag;
      if (is_x0(qry_reg)) begin
         qry_value  = '0;
         qry_busy   = 1'b0;
         qry_rob_id = '0;
      end else if (bypass_hit) begin
         qry_value = commit_value;
         qry_busy  = 1'b0;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags; commits from ROB, renames from Decoder, two queries.
// Updates on posedge clk_in when rdy_in=1 (rdy_in low holds all state); queries 0-cycle; RF_COMMIT_BYPASS_EN optional.
import reg_file_pkg::*;

module reg_file #(
   parameter int ROB_SIZE_BIT = reg_file_pkg::ROB_SIZE_BIT,
   parameter int REG_NUM      = reg_file_pkg::REG_NUM
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    rob_clear,
   input  logic                    commit_en,
   input  logic [REG_ID_BIT-1:0]   commit_reg,
   input  logic [XLEN-1:0]         commit_value,
   input  logic [ROB_SIZE_BIT-1:0] commit_rob_id,
   input  logic                    rename_en,
   input  logic [REG_ID_BIT-1:0]   rename_reg,
   input  logic [ROB_SIZE_BIT-1:0] rename_rob_id,
   input  logic [REG_ID_BIT-1:0]   qry1_reg,
   output logic [XLEN-1:0]         qry1_value,
   output logic                    qry1_busy,
   output logic [ROB_SIZE_BIT-1:0] qry1_rob_id,
   input  logic [REG_ID_BIT-1:0]   qry2_reg,
   output logic [XLEN-1:0]         qry2_value,
   output logic                    qry2_busy,
   output logic [ROB_SIZE_BIT-1:0] qry2_rob_id
);

   typedef logic [ROB_SIZE_BIT-1:0] rob_id_t;

   word_t              value_q [REG_NUM];
   word_t              value_d [REG_NUM];
   logic [REG_NUM-1:0] busy_q;
   logic [REG_NUM-1:0] busy_d;
   rob_id_t            tag_q   [REG_NUM];
   rob_id_t            tag_d   [REG_NUM];

   always_comb begin
      value_d = value_q;
      busy_d  = busy_q;
      tag_d   = tag_q;
      if (rdy_in) begin
         if (commit_en && !is_x0(commit_reg)) begin
            value_d[commit_reg] = commit_value;
            // A younger rename owns the tag; only the matching producer releases busy.
            if (busy_q[commit_reg] && (tag_q[commit_reg] == commit_rob_id))
               busy_d[commit_reg] = 1'b0;
         end
         if (rob_clear) begin
            busy_d = '0;
         end else if (rename_en && !is_x0(rename_reg)) begin
            busy_d[rename_reg] = 1'b1;
            tag_d[rename_reg]  = rename_rob_id;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   rf_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_rd1 (
      .qry_reg       (qry1_reg),
      .reg_value     (value_q[qry1_reg]),
      .reg_busy      (busy_q[qry1_reg]),
      .reg_tag       (tag_q[qry1_reg]),
      .commit_en     (commit_en),
      .commit_reg    (commit_reg),
      .commit_value  (commit_value),
      .commit_rob_id (commit_rob_id),
      .qry_value     (qry1_value),
      .qry_busy      (qry1_busy),
      .qry_rob_id    (qry1_rob_id)
   );

   rf_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_rd2 (
      .qry_reg       (qry2_reg),
      .reg_value     (value_q[qry2_reg]),
      .reg_busy      (busy_q[qry2_reg]),
      .reg_tag       (tag_q[qry2_reg]),
      .commit_en     (commit_en),
      .commit_reg    (commit_reg),
      .commit_value  (commit_value),
      .commit_rob_id (commit_rob_id),
      .qry_value     (qry2_value),
      .qry_busy      (qry2_busy),
      .qry_rob_id    (qry2_rob_id)
   );

endmodule

// File: tb/tb_reg_file.sv
// Directed test-plan scenarios plus randomized traffic against an array-based register model.
module tb_reg_file;

   localparam int RB = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic          rob_clear;
   logic          commit_en;
   logic [4:0]    commit_reg;
   logic [31:0]   commit_value;
   logic [RB-1:0] commit_rob_id;
   logic          rename_en;
   logic [4:0]    rename_reg;
   logic [RB-1:0] rename_rob_id;
   logic [4:0]    qry1_reg;
   logic [31:0]   qry1_value;
   logic          qry1_busy;
   logic [RB-1:0] qry1_rob_id;
   logic [4:0]    qry2_reg;
   logic [31:0]   qry2_value;
   logic          qry2_busy;
   logic [RB-1:0] qry2_rob_id;

   reg_file #(.ROB_SIZE_BIT(RB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .commit_en(commit_en), .commit_reg(commit_reg), .commit_value(commit_value),
      .commit_rob_id(commit_rob_id), .rename_en(rename_en), .rename_reg(rename_reg),
      .rename_rob_id(rename_rob_id),
      .qry1_reg(qry1_reg), .qry1_value(qry1_value), .qry1_busy(qry1_busy), .qry1_rob_id(qry1_rob_id),
      .qry2_reg(qry2_reg), .qry2_value(qry2_value), .qry2_busy(qry2_busy), .qry2_rob_id(qry2_rob_id)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0]   m_val  [32];
   bit            m_busy [32];
   logic [RB-1:0] m_tag  [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected query answer from the architectural model and the inputs currently driven.
   task automatic check_port(input string name, input logic [4:0] r, input logic [31:0] v,
                             input logic b, input logic [RB-1:0] id);
      logic [31:0]   ev;
      logic          eb;
      logic [RB-1:0] eid;
      ev  = m_val[r];
      eb  = m_busy[r];
      eid = m_tag[r];
      if (r == 5'd0) begin
         ev = 32'd0;
         eb = 1'b0;
      end
`ifdef RF_COMMIT_BYPASS_EN
      if (commit_en && commit_reg == r && r != 5'd0 && m_busy[r] && m_tag[r] == commit_rob_id) begin
         ev = commit_value;
         eb = 1'b0;
      end
`endif
      check({name, "_busy"}, 32'(b), 32'(eb));
      if (eb) check({name, "_rob_id"}, 32'(id), 32'(eid));
      else    check({name, "_value"}, v, ev);
   endtask

   function automatic void model_step();
      if (!rdy_in) return;
      if (commit_en && commit_reg != 5'd0) begin
         m_val[commit_reg] = commit_value;
         if (m_busy[commit_reg] && m_tag[commit_reg] == commit_rob_id) m_busy[commit_reg] = 1'b0;
      end
      if (rob_clear) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (rename_en && rename_reg != 5'd0) begin
         m_busy[rename_reg] = 1'b1;
         m_tag[rename_reg]  = rename_rob_id;
      end
   endfunction

   task automatic idle();
      rdy_in = 1'b1; rob_clear = 1'b0;
      commit_en = 1'b0; commit_reg = '0; commit_value = '0; commit_rob_id = '0;
      rename_en = 1'b0; rename_reg = '0; rename_rob_id = '0;
   endtask

   // Check both ports against the model, clock once, advance the model.
   task automatic cyc();
      #1;
      check_port("q1", qry1_reg, qry1_value, qry1_busy, qry1_rob_id);
      check_port("q2", qry2_reg, qry2_value, qry2_busy, qry2_rob_id);
      @(posedge clk_in);
      model_step();
      #1;
   endtask

   task automatic rename(input logic [4:0] r, input logic [RB-1:0] id);
      idle(); rename_en = 1'b1; rename_reg = r; rename_rob_id = id;
      cyc();
   endtask

   task automatic commit(input logic [4:0] r, input logic [RB-1:0] id, input logic [31:0] v);
      idle(); commit_en = 1'b1; commit_reg = r; commit_rob_id = id; commit_value = v;
      cyc();
   endtask

   task automatic look(input logic [4:0] r1, input logic [4:0] r2);
      idle(); qry1_reg = r1; qry2_reg = r2;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      rst_in = 1'b1;
      idle();
      qry1_reg = 5'd5; qry2_reg = 5'd9;
      @(posedge clk_in); @(posedge clk_in); #1;
      check("rst_q1_value", qry1_value, 32'd0);
      check("rst_q1_busy", 32'(qry1_busy), 32'd0);
      check("rst_q2_rob_id", 32'(qry2_rob_id), 32'd0);
      rst_in = 1'b0;

      // x0 ignores renames
      rename(5'd0, 4'd3);
      look(5'd0, 5'd5);
      check("x0_busy", 32'(qry1_busy), 32'd0);
      check("x0_value", qry1_value, 32'd0);
      check("x5_after_rst", 32'(qry2_busy), 32'd0);

      rename(5'd5, 4'd2);
      look(5'd5, 5'd0);
      check("x5_busy", 32'(qry1_busy), 32'd1);
      check("x5_rob_id", 32'(qry1_rob_id), 32'd2);
      commit(5'd5, 4'd2, 32'hDEADBEEF);
      look(5'd0, 5'd5);
      check("x5_value", qry2_value, 32'hDEADBEEF);
      check("x5_released", 32'(qry2_busy), 32'd0);

      // Older commit must not release a younger rename
      rename(5'd7, 4'd1);
      rename(5'd7, 4'd4);
      commit(5'd7, 4'd1, 32'h11);
      look(5'd7, 5'd7);
      check("x7_value", qry1_value, 32'h11);
      check("x7_busy", 32'(qry1_busy), 32'd1);
      check("x7_rob_id", 32'(qry2_rob_id), 32'd4);

      idle();
      commit_en = 1'b1; commit_reg = 5'd9; commit_rob_id = 4'd6; commit_value = 32'h55;
      rename_en = 1'b1; rename_reg = 5'd9; rename_rob_id = 4'd7;
      cyc();
      look(5'd9, 5'd0);
      check("x9_value", qry1_value, 32'h55);
      check("x9_busy", 32'(qry1_busy), 32'd1);
      check("x9_rob_id", 32'(qry1_rob_id), 32'd7);

      rename(5'd3, 4'd8);
      rename(5'd4, 4'd9);
      idle();
      rob_clear = 1'b1;
      commit_en = 1'b1; commit_reg = 5'd3; commit_rob_id = 4'd0; commit_value = 32'h99;
      rename_en = 1'b1; rename_reg = 5'd8; rename_rob_id = 4'd10;
      cyc();
      look(5'd3, 5'd4);
      check("clr_x3_value", qry1_value, 32'h99);
      check("clr_x3_busy", 32'(qry1_busy), 32'd0);
      check("clr_x4_busy", 32'(qry2_busy), 32'd0);
      look(5'd8, 5'd7);
      check("clr_x8_busy", 32'(qry1_busy), 32'd0);
      check("clr_x7_busy", 32'(qry2_busy), 32'd0);

      rename(5'd6, 4'd5);
      idle();
      commit_en = 1'b1; commit_reg = 5'd6; commit_rob_id = 4'd5; commit_value = 32'h42;
      qry1_reg = 5'd6;
      #1;
`ifdef RF_COMMIT_BYPASS_EN
      check("byp_value", qry1_value, 32'h42);
      check("byp_busy", 32'(qry1_busy), 32'd0);
`else
      check("byp_busy", 32'(qry1_busy), 32'd1);
      check("byp_rob_id", 32'(qry1_rob_id), 32'd5);
`endif
      cyc();
      look(5'd6, 5'd0);
      check("x6_value", qry1_value, 32'h42);
      check("x6_busy", 32'(qry1_busy), 32'd0);

      // rdy_in low freezes everything, including clear
      rename(5'd10, 4'd3);
      idle();
      rdy_in = 1'b0; rob_clear = 1'b1;
      commit_en = 1'b1; commit_reg = 5'd10; commit_rob_id = 4'd3; commit_value = 32'h77;
      rename_en = 1'b1; rename_reg = 5'd11; rename_rob_id = 4'd8;
      qry1_reg = 5'd10; qry2_reg = 5'd11;
      cyc(); cyc(); cyc();
      look(5'd10, 5'd11);
      check("hold_x10_busy", 32'(qry1_busy), 32'd1);
      check("hold_x10_rob_id", 32'(qry1_rob_id), 32'd3);
      check("hold_x11_busy", 32'(qry2_busy), 32'd0);
      cyc();
      look(5'd10, 5'd5);
      check("resume_x10_busy", 32'(qry1_busy), 32'd1);
      check("resume_x5_value", qry2_value, 32'hDEADBEEF);

      for (int n = 0; n < 600; n++) begin
         idle();
         rdy_in        = ($urandom_range(0, 9) != 0);
         rob_clear     = ($urandom_range(0, 24) == 0);
         commit_en     = ($urandom_range(0, 1) == 1);
         commit_reg    = 5'($urandom_range(0, 7));
         commit_value  = $urandom;
         commit_rob_id = RB'($urandom_range(0, 15));
         rename_en     = ($urandom_range(0, 1) == 1);
         rename_reg    = 5'($urandom_range(0, 7));
         rename_rob_id = RB'($urandom_range(0, 15));
         qry1_reg      = ($urandom_range(0, 3) == 0) ? commit_reg : 5'($urandom_range(0, 31));
         qry2_reg      = 5'($urandom_range(0, 7));
         if (commit_en && $urandom_range(0, 1) == 1 && m_busy[commit_reg])
            commit_rob_id = m_tag[commit_reg];
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
